// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and default sizing for the CAM sequencing
//               controller: FSM state encoding, arbitration grant encoding
//               and the default key width / row count.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    // Default sizing used by cam_ctrl when not overridden.
    localparam int c_data_w = 8;
    localparam int c_depth  = 8;

    // Controller states. The encoding is explicit so that waveform values
    // stay the same across tool versions.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        SEARCH = 3'd2,
        RESP   = 3'd3,
        FLUSH  = 3'd4
    } cam_state_e;

    // Identity of the requester that won the most recent arbitration.
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_SR = 1'b1
    } cam_grant_e;

endpackage : cam_pkg
`default_nettype wire

// File: rtl/cam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : cam_prio_enc
// Description : Purely combinational priority encoder for a CAM hit vector.
//               Reports whether any row hit, the lowest hitting row index
//               (0 when nothing hit) and whether more than one row hit.
// Ports       : i_hitvec  DEPTH  per-row hit flags (already qualified)
//               o_hit     1      at least one flag set
//               o_index   IDX_W  lowest set flag position, 0 on miss
//               o_multi   1      two or more flags set
// Revision    : 1.0 - initial release
// ============================================================================
module cam_prio_enc #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_hitvec,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_index,
    output logic             o_multi
);

    logic [IDX_W-1:0] w_index;
    logic [DEPTH-1:0] w_rest;

    // Walk from the top row down so the last assignment wins, which leaves
    // the lowest set position in w_index.
    always_comb begin
        w_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_hitvec[i]) begin
                w_index = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if a second bit
    // was set, which gives the multi-hit flag without a population count.
    assign w_rest  = i_hitvec & (i_hitvec - DEPTH'(1));

    assign o_hit   = |i_hitvec;
    assign o_index = w_index;
    assign o_multi = |w_rest;

endmodule : cam_prio_enc
`default_nettype wire

// File: rtl/cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_ctrl
// Description : Sequencing and arbitration controller for a DEPTH-row CAM
//               built from flip-flop cells. Accepts write/invalidate and
//               search requests on valid/ready handshakes, arbitrates them
//               round-robin, drives the array's row write enables and search
//               strobe, tracks per-row valid bits and returns a priority
//               encoded result on a valid/ready response channel.
// Ports       : clk_i               clock, rising edge
//               reset               synchronous active-high reset
//               flush_i/flush_ack_o clear-all request / one-cycle ack pulse
//               wr_*                write request channel (index, key, clear)
//               sr_*                search request channel (key)
//               rsp_*               search response (hit, lowest index, multi)
//               cam_reset_o         array reset (reset or flush in progress)
//               cam_write_enable_o  one-hot row write enable to the array
//               cam_data_o          write key to the array
//               cam_search_enable_o search strobe to the array
//               cam_search_o        search key to the array
//               cam_match_i         per-row combinational match from array
// Revision    : 1.0 - initial release
// ============================================================================
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset,

    input  logic              flush_i,
    output logic              flush_ack_o,

    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [IDX_W-1:0]  wr_index_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_clear_i,

    input  logic              sr_valid_i,
    output logic              sr_ready_o,
    input  logic [DATA_W-1:0] sr_data_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_hit_o,
    output logic [IDX_W-1:0]  rsp_index_o,
    output logic              rsp_multi_o,

    output logic              cam_reset_o,
    output logic [DEPTH-1:0]  cam_write_enable_o,
    output logic [DATA_W-1:0] cam_data_o,
    output logic              cam_search_enable_o,
    output logic [DATA_W-1:0] cam_search_o,
    input  logic [DEPTH-1:0]  cam_match_i
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cam_state_e        r_state;
    cam_grant_e        r_last_grant;
    logic [DEPTH-1:0]  r_valid;      // per-row "holds a live key" flags
    logic [DEPTH-1:0]  r_row_sel;    // latched write target, one-hot
    logic              r_clear;      // latched invalidate request
    logic [DATA_W-1:0] r_data;       // latched write key
    logic [DATA_W-1:0] r_key;        // latched search key
    logic [DEPTH-1:0]  r_hitvec;     // qualified match vector for RESP
    logic [DEPTH-1:0]  r_write_en;
    logic              r_search_en;
    logic              r_flush_ack;
    logic              r_rsp_valid;

    logic [DEPTH-1:0]  w_wr_onehot;
    logic              w_idle;
    logic              w_wr_grant;
    logic              w_sr_grant;

    // ------------------------------------------------------------------
    // Row decode of the incoming write index. Rows only exist below
    // DEPTH, so an index that names no row decodes to all zeros: it
    // produces no write enable and leaves every valid bit untouched.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row_dec
            assign w_wr_onehot[gi] = (wr_index_i == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request acceptance. Readies are offered only in IDLE and only when
    // no flush is pending. When both requesters are valid, the one that
    // did not win last time gets the ready, so the two readies are never
    // high together while both requests are pending.
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == IDLE) && !reset;
    assign wr_ready_o = w_idle && !flush_i &&
                        (!sr_valid_i || (r_last_grant == GRANT_SR));
    assign sr_ready_o = w_idle && !flush_i &&
                        (!wr_valid_i || (r_last_grant == GRANT_WR));

    assign w_wr_grant = wr_valid_i && wr_ready_o;
    assign w_sr_grant = sr_valid_i && sr_ready_o;

    // ------------------------------------------------------------------
    // Controller FSM. The strobe outputs are registered: they are set on
    // the edge that enters the state they belong to and dropped by the
    // per-cycle default on the edge that leaves it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_SR;
            r_valid      <= '0;
            r_row_sel    <= '0;
            r_clear      <= 1'b0;
            r_data       <= '0;
            r_key        <= '0;
            r_hitvec     <= '0;
            r_write_en   <= '0;
            r_search_en  <= 1'b0;
            r_flush_ack  <= 1'b0;
            r_rsp_valid  <= 1'b0;
        end else begin
            r_write_en  <= '0;
            r_search_en <= 1'b0;
            r_flush_ack <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (flush_i) begin
                        r_flush_ack <= 1'b1;
                        r_state     <= FLUSH;
                    end else if (w_wr_grant) begin
                        r_row_sel    <= w_wr_onehot;
                        r_clear      <= wr_clear_i;
                        r_data       <= wr_data_i;
                        // An invalidate only drops the valid bit; the cell
                        // contents are left alone.
                        r_write_en   <= wr_clear_i ? '0 : w_wr_onehot;
                        r_last_grant <= GRANT_WR;
                        r_state      <= WRITE;
                    end else if (w_sr_grant) begin
                        r_key        <= sr_data_i;
                        r_search_en  <= 1'b1;
                        r_last_grant <= GRANT_SR;
                        r_state      <= SEARCH;
                    end
                end

                WRITE: begin
                    if (r_clear) begin
                        r_valid <= r_valid & ~r_row_sel;
                    end else begin
                        r_valid <= r_valid | r_row_sel;
                    end
                    r_state <= IDLE;
                end

                SEARCH: begin
                    // Rows that were never written (or were invalidated)
                    // may still match on stale cell contents; mask them.
                    r_hitvec    <= cam_match_i & r_valid;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                FLUSH: begin
                    r_valid <= '0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result encoding. r_hitvec only changes on the SEARCH edge, so the
    // response fields stay stable for as long as RESP is back-pressured.
    // ------------------------------------------------------------------
    cam_prio_enc #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_hitvec (r_hitvec),
        .o_hit    (rsp_hit_o),
        .o_index  (rsp_index_o),
        .o_multi  (rsp_multi_o)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_valid_o         = r_rsp_valid;
    assign flush_ack_o         = r_flush_ack;
    assign cam_reset_o         = reset || (r_state == FLUSH);
    assign cam_write_enable_o  = r_write_en;
    assign cam_data_o          = r_data;
    assign cam_search_enable_o = r_search_en;
    assign cam_search_o        = r_key;

endmodule : cam_ctrl
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_ctrl
// Description : Self-checking bench for cam_ctrl. Includes a behavioural
//               flip-flop CAM array on the cam_* side, a reference model of
//               row contents/valid bits, and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;

    logic              clk_i = 1'b0;
    logic              reset;
    logic              flush_i;
    logic              flush_ack_o;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [IDX_W-1:0]  wr_index_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_clear_i;
    logic              sr_valid_i;
    logic              sr_ready_o;
    logic [DATA_W-1:0] sr_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_hit_o;
    logic [IDX_W-1:0]  rsp_index_o;
    logic              rsp_multi_o;
    logic              cam_reset_o;
    logic [DEPTH-1:0]  cam_write_enable_o;
    logic [DATA_W-1:0] cam_data_o;
    logic              cam_search_enable_o;
    logic [DATA_W-1:0] cam_search_o;
    logic [DEPTH-1:0]  cam_match_i;

    always #5 clk_i = ~clk_i;

    cam_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk_i               (clk_i),
        .reset               (reset),
        .flush_i             (flush_i),
        .flush_ack_o         (flush_ack_o),
        .wr_valid_i          (wr_valid_i),
        .wr_ready_o          (wr_ready_o),
        .wr_index_i          (wr_index_i),
        .wr_data_i           (wr_data_i),
        .wr_clear_i          (wr_clear_i),
        .sr_valid_i          (sr_valid_i),
        .sr_ready_o          (sr_ready_o),
        .sr_data_i           (sr_data_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_hit_o           (rsp_hit_o),
        .rsp_index_o         (rsp_index_o),
        .rsp_multi_o         (rsp_multi_o),
        .cam_reset_o         (cam_reset_o),
        .cam_write_enable_o  (cam_write_enable_o),
        .cam_data_o          (cam_data_o),
        .cam_search_enable_o (cam_search_enable_o),
        .cam_search_o        (cam_search_o),
        .cam_match_i         (cam_match_i)
    );

    // Behavioural flip-flop CAM array.
    logic [DATA_W-1:0] cells [DEPTH];

    always @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_reset_o) cells[i] <= '0;
            else if (cam_write_enable_o[i]) cells[i] <= cam_data_o;
        end
    end

    always_comb begin
        cam_match_i = '0;
        for (int i = 0; i < DEPTH; i++)
            cam_match_i[i] = cam_search_enable_o && (cells[i] == cam_search_o);
    end

    // Reference model of what the controller should believe.
    logic              ref_valid [DEPTH];
    logic [DATA_W-1:0] ref_key   [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Expected response packed as {hit, index[2:0], multi}.
    function automatic logic [4:0] predict(input logic [DATA_W-1:0] key);
        logic [IDX_W-1:0] idx;
        int               cnt;
        idx = '0;
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_valid[i] && ref_key[i] == key) begin
                if (cnt == 0) idx = IDX_W'(i);
                cnt++;
            end
        end
        return {(cnt > 0), idx, (cnt > 1)};
    endfunction

    // Scoreboard: expectations pushed at search acceptance, popped when the
    // response handshake completes.
    logic [4:0] sb_q [$];
    logic [4:0] sb_e;

    always @(negedge clk_i) begin
        if (rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_rsp", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                check("rsp_hit",   rsp_hit_o,   sb_e[4]);
                check("rsp_index", rsp_index_o, sb_e[3:1]);
                check("rsp_multi", rsp_multi_o, sb_e[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < DEPTH; i++) begin
            ref_valid[i] = 1'b0;
            ref_key[i]   = '0;
        end
    endtask

    task automatic do_write(input int idx, input logic [DATA_W-1:0] data, input logic clr);
        int               t;
        logic [DEPTH-1:0] exp_we;
        tick();
        wr_valid_i = 1'b1;
        wr_index_i = IDX_W'(idx);
        wr_data_i  = data;
        wr_clear_i = clr;
        t = 0;
        @(negedge clk_i);
        while (!wr_ready_o && t < 20) begin
            tick();
            @(negedge clk_i);
            t++;
        end
        if (t >= 20) begin
            check("wr_accept_timeout", 0, 1);
            wr_valid_i = 1'b0;
            return;
        end
        tick();
        wr_valid_i = 1'b0;
        exp_we = clr ? '0 : (DEPTH'(1) << idx);
        @(negedge clk_i);
        check("write_enable", cam_write_enable_o, exp_we);
        if (!clr) check("write_data", cam_data_o, data);
        check("write_no_search", cam_search_enable_o, 0);
        tick();
        @(negedge clk_i);
        check("write_enable_off", cam_write_enable_o, 0);
        ref_valid[idx] = !clr;
        if (!clr) ref_key[idx] = data;
    endtask

    task automatic do_search(input logic [DATA_W-1:0] key, input int hold);
        int         t;
        logic [4:0] e;
        tick();
        sr_valid_i = 1'b1;
        sr_data_i  = key;
        t = 0;
        @(negedge clk_i);
        while (!sr_ready_o && t < 20) begin
            tick();
            @(negedge clk_i);
            t++;
        end
        if (t >= 20) begin
            check("sr_accept_timeout", 0, 1);
            sr_valid_i = 1'b0;
            return;
        end
        tick();                                   // cycle N+1
        sr_valid_i = 1'b0;
        e = predict(key);
        sb_q.push_back(e);
        @(negedge clk_i);
        check("search_strobe",    cam_search_enable_o, 1);
        check("search_key",       cam_search_o, key);
        check("search_rsp_early", rsp_valid_o, 0);
        check("search_no_write",  cam_write_enable_o, 0);
        tick();                                   // cycle N+2
        @(negedge clk_i);
        check("rsp_valid_n2",   rsp_valid_o, 1);
        check("rsp_strobe_off", cam_search_enable_o, 0);
        for (int k = 0; k < hold; k++) begin
            tick();
            @(negedge clk_i);
            check("hold_valid", rsp_valid_o, 1);
            check("hold_hit",   rsp_hit_o,   e[4]);
            check("hold_index", rsp_index_o, e[3:1]);
            check("hold_multi", rsp_multi_o, e[0]);
            check("hold_readies", {wr_ready_o, sr_ready_o}, 0);
        end
        tick();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("rsp_cycle_no_ready", {wr_ready_o, sr_ready_o}, 0);
        tick();
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("rsp_done",       rsp_valid_o, 0);
        check("idle_after_rsp", {wr_ready_o, sr_ready_o}, 2'b11);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cyc;

        reset       = 1'b1;
        flush_i     = 1'b0;
        wr_valid_i  = 1'b0;
        wr_index_i  = '0;
        wr_data_i   = '0;
        wr_clear_i  = 1'b0;
        sr_valid_i  = 1'b0;
        sr_data_i   = '0;
        rsp_ready_i = 1'b0;
        clear_ref();

        // Reset state
        repeat (2) tick();
        @(negedge clk_i);
        check("rst_cam_reset_high", cam_reset_o, 1);
        check("rst_readies", {wr_ready_o, sr_ready_o}, 0);
        tick();
        reset = 1'b0;
        @(negedge clk_i);
        check("rst_rsp_valid",  rsp_valid_o, 0);
        check("rst_write_en",   cam_write_enable_o, 0);
        check("rst_search_en",  cam_search_enable_o, 0);
        check("rst_flush_ack",  flush_ack_o, 0);
        check("rst_cam_data",   cam_data_o, 0);
        check("rst_cam_search", cam_search_o, 0);
        check("rst_cam_reset",  cam_reset_o, 0);
        check("rst_idle_ready", {wr_ready_o, sr_ready_o}, 2'b11);

        // Unwritten rows never hit even though cells hold 0
        do_search(8'h00, 0);

        // Single write then hit
        do_write(3, 8'hA5, 1'b0);
        do_search(8'hA5, 0);

        // Multiple hits, then invalidate the lower one
        do_write(6, 8'h3C, 1'b0);
        do_write(1, 8'h3C, 1'b0);
        do_search(8'h3C, 0);
        do_write(1, 8'h00, 1'b1);
        do_search(8'h3C, 0);

        // Back-pressured response
        do_search(8'hA5, 5);

        // Flush
        tick();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_readies", {wr_ready_o, sr_ready_o}, 0);
        check("flush_ack_early", flush_ack_o, 0);
        tick();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_ack", flush_ack_o, 1);
        check("flush_cam_reset", cam_reset_o, 1);
        tick();
        @(negedge clk_i);
        check("flush_ack_off", flush_ack_o, 0);
        check("flush_cam_reset_off", cam_reset_o, 0);
        clear_ref();
        do_search(8'hA5, 0);
        do_search(8'h00, 0);

        // Reset asserted while in SEARCH
        do_write(6, 8'h3C, 1'b0);
        tick();
        sr_valid_i = 1'b1;
        sr_data_i  = 8'h3C;
        @(negedge clk_i);
        check("pre_reset_sr_ready", sr_ready_o, 1);
        tick();
        sr_valid_i = 1'b0;
        reset      = 1'b1;
        @(negedge clk_i);
        check("midsearch_strobe", cam_search_enable_o, 1);
        check("midsearch_cam_reset", cam_reset_o, 1);
        tick();
        reset = 1'b0;
        clear_ref();
        @(negedge clk_i);
        check("postreset_rsp_valid", rsp_valid_o, 0);
        check("postreset_strobe", cam_search_enable_o, 0);
        check("postreset_idle", {wr_ready_o, sr_ready_o}, 2'b11);

        // Round-robin with both requesters held valid, straight after reset
        tick();
        wr_valid_i  = 1'b1;
        wr_index_i  = 3'd2;
        wr_data_i   = 8'h77;
        wr_clear_i  = 1'b0;
        sr_valid_i  = 1'b1;
        sr_data_i   = 8'h77;
        rsp_ready_i = 1'b1;
        g   = 0;
        cyc = 0;
        while (g < 4 && cyc < 60) begin
            @(negedge clk_i);
            check("arb_exclusive", wr_ready_o & sr_ready_o, 0);
            if (wr_valid_i && wr_ready_o) begin
                check("arb_grant", 0, (g % 2 == 0) ? 0 : 1);
                ref_valid[2] = 1'b1;
                ref_key[2]   = 8'h77;
                g++;
            end else if (sr_valid_i && sr_ready_o) begin
                check("arb_grant", 1, (g % 2 == 0) ? 0 : 1);
                sb_q.push_back(predict(8'h77));
                g++;
            end
            tick();
            cyc++;
        end
        wr_valid_i = 1'b0;
        sr_valid_i = 1'b0;
        if (g < 4) check("arb_timeout", g, 4);
        repeat (4) tick();
        rsp_ready_i = 1'b0;

        // Valid bits were cleared by reset: cell zeros must not hit
        do_search(8'h00, 0);
        do_search(8'h77, 0);

        tick();
        check("sb_drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cam_ctrl
`default_nettype wire
